// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: ALU op codes and FSM state encodings.
package alu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'b00001;
  localparam logic [4:0] ALU_NEG   = 5'b00010;
  localparam logic [4:0] ALU_SUB   = 5'b00011;
  localparam logic [4:0] ALU_MUL   = 5'b00100;
  localparam logic [4:0] ALU_DIV   = 5'b01000;
  localparam logic [4:0] ALU_REM   = 5'b01001;
  localparam logic [4:0] ALU_AND   = 5'b01010;
  localparam logic [4:0] ALU_OR    = 5'b01100;
  localparam logic [4:0] ALU_PASSB = 5'b11000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of both requesters plus the ALU-side handshake.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*OPW-1:0]   req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [WIDTH-1:0]   resp_data;
  logic               resp_err;
  logic               alu_en;
  logic [OPW-1:0]     alu_op;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_data_out;
  logic               alu_valid;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_data_out, alu_valid,
    output req_ready, resp_valid, resp_data, resp_err, alu_en, alu_op, alu_a, alu_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_data_out, alu_valid,
    input  req_ready, resp_valid, resp_data, resp_err, alu_en, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins; on contention the one not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between execute (port 0) and address generation (port 1),
// one operation in flight, result returned on a per-requester valid/ready channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OPW     = 5,
  parameter int TIMEOUT = 8
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]       r_state;
  logic             r_last;
  logic             r_owner;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic [CW-1:0]    r_cnt;

  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_sel;
  logic             w_div0;
  logic [OPW-1:0]   w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  rr_arb2 u_arb (
    .req   (bus.req_valid),
    .last  (r_last),
    .grant (w_grant)
  );

  assign w_accept = (r_state == S_IDLE) && (w_grant != 2'b00);
  assign w_sel    = w_grant[1];
  assign w_op     = w_sel ? bus.req_op[2*OPW-1:OPW]     : bus.req_op[OPW-1:0];
  assign w_a      = w_sel ? bus.req_a[2*WIDTH-1:WIDTH]  : bus.req_a[WIDTH-1:0];
  assign w_b      = w_sel ? bus.req_b[2*WIDTH-1:WIDTH]  : bus.req_b[WIDTH-1:0];

  // Divide/remainder by zero never reaches the ALU; answer straight from IDLE.
  assign w_div0 = ((w_op == OPW'(ALU_DIV)) || (w_op == OPW'(ALU_REM))) && (w_b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_owner <= w_sel;
            r_last  <= w_sel;
            if (w_div0) begin
              r_data  <= '1;
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.alu_valid) begin
            r_data  <= bus.alu_data_out;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_data  <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready[r_owner]) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE) ? w_grant : 2'b00;
  assign bus.resp_valid = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_data  = r_data;
  assign bus.resp_err   = r_err;
  assign bus.alu_en     = (r_state == S_ISSUE);
  assign bus.alu_op     = r_op;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_resp_valid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.resp_valid));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 1-cycle ALU (latency/suppression knobs).
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int OPW     = 5;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // requester drive state
  logic             rv  [2];
  logic [OPW-1:0]   rop [2];
  logic [WIDTH-1:0] ra  [2];
  logic [WIDTH-1:0] rb  [2];
  logic [1:0]       rrdy = 2'b11;
  int               rr_mode = 0;

  assign bus.req_valid  = {rv[1], rv[0]};
  assign bus.req_op     = {rop[1], rop[0]};
  assign bus.req_a      = {ra[1], ra[0]};
  assign bus.req_b      = {rb[1], rb[0]};
  assign bus.resp_ready = rrdy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_NEG:   return -a;
      ALU_SUB:   return a - b;
      ALU_MUL:   return a * b;
      ALU_DIV:   return (b == 0) ? '1 : a / b;
      ALU_REM:   return (b == 0) ? a : a % b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_PASSB: return b;
      default:   return '0;
    endcase
  endfunction

  // behavioural ALU: result valid alu_lat cycles after a sampled alu_en
  int               alu_lat = 1;
  bit               alu_sup = 1'b0;
  int               a_cnt   = 0;
  logic [WIDTH-1:0] a_res   = '0;
  always @(posedge clk) begin
    if (bus.alu_en && !alu_sup) begin
      a_cnt <= alu_lat;
      a_res <= ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
    end else if (a_cnt != 0) begin
      a_cnt <= a_cnt - 1;
    end
  end
  assign bus.alu_valid    = (a_cnt == 1);
  assign bus.alu_data_out = (a_cnt == 1) ? a_res : '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [1:0]       owner;
    logic [WIDTH-1:0] data;
    logic             err;
    int               lat;
    bit               div0;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } exp_t;

  exp_t sbq[$];
  bit   m_busy   = 1'b0;
  bit   m_last   = 1'b1;
  int   acc_cyc  = 0;
  bit   rst_seen = 1'b0;

  function automatic logic [1:0] model_grant(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  always @(negedge clk) begin
    logic [1:0] g;
    exp_t       e;
    int         w;
    if (rst) begin
      m_busy   = 1'b0;
      m_last   = 1'b1;
      sbq.delete();
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        check("rst_alu_en", bus.alu_en, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_alu_operands", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        check("rst_resp_data_err", {bus.resp_data, bus.resp_err}, 0);
        rst_seen = 1'b0;
      end
      g = m_busy ? 2'b00 : model_grant({rv[1], rv[0]}, m_last);
      check("req_ready", bus.req_ready, g);
      if (m_busy) begin
        e = sbq[0];
        check("alu_en", bus.alu_en, (!e.div0 && cyc == acc_cyc + 1));
        if (!e.div0 && cyc > acc_cyc)
          check("alu_operands", {bus.alu_op, bus.alu_a, bus.alu_b}, {e.op, e.a, e.b});
        check("resp_valid", bus.resp_valid, (cyc >= acc_cyc + e.lat) ? e.owner : 2'b00);
        if (cyc >= acc_cyc + e.lat) begin
          check("resp_data", bus.resp_data, e.data);
          check("resp_err", bus.resp_err, e.err);
          if ((e.owner & rrdy) != 2'b00) begin
            void'(sbq.pop_front());
            m_busy = 1'b0;
          end
        end
      end else begin
        check("idle_alu_en", bus.alu_en, 0);
        check("idle_resp_valid", bus.resp_valid, 0);
      end
      if (g != 2'b00) begin
        w       = g[1] ? 1 : 0;
        e.owner = g;
        e.op    = rop[w];
        e.a     = ra[w];
        e.b     = rb[w];
        e.div0  = (rop[w] == ALU_DIV || rop[w] == ALU_REM) && rb[w] == 0;
        if (e.div0) begin
          e.data = '1; e.err = 1'b1; e.lat = 1;
        end else if (alu_sup || alu_lat > TIMEOUT) begin
          e.data = '0; e.err = 1'b1; e.lat = 2 + TIMEOUT;
        end else begin
          e.data = ref_alu(rop[w], ra[w], rb[w]); e.err = 1'b0; e.lat = 2 + alu_lat;
        end
        sbq.push_back(e);
        m_busy  = 1'b1;
        m_last  = (w == 1);
        acc_cyc = cyc;
      end
    end
  end

  // response-ready policy: 0 always ready, 1 random, 2 held low
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       rrdy = 2'b11;
      1:       rrdy = 2'($urandom);
      default: rrdy = 2'b00;
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int i, input logic [OPW-1:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit got = 1'b0;
    rop[i] = op; ra[i] = a; rb[i] = b; rv[i] = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (!rst && bus.req_ready[i]) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: requester %0d got no req_ready, expected accept within 400 cycles", i);
    end
    @(posedge clk); #1;
    rv[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (!m_busy && sbq.size() == 0 && !rv[0] && !rv[1]) done = 1'b1;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: response still outstanding, expected completion within 400 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rnd_drive(input int i);
    logic [4:0] ops [10];
    logic [WIDTH-1:0] a, b;
    ops = '{ALU_ADD, ALU_NEG, ALU_SUB, ALU_MUL, ALU_DIV, ALU_REM, ALU_AND, ALU_OR, ALU_PASSB, 5'b00111};
    a = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 1000)) : WIDTH'($urandom);
    b = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom_range(1, 50));
    drive(i, ops[$urandom_range(0, 9)], a, b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rop[i] = '0; ra[i] = '0; rb[i] = '0;
    end
    do_reset(3);

    // T1: single ADD
    drive(0, ALU_ADD, 5, 7);
    wait_idle();

    // T2: contention from reset, requesters reissue so pairs keep colliding
    do_reset(2);
    fork
      begin drive(0, ALU_SUB, 10, 3); drive(0, ALU_AND, 32'hF0F0, 32'h0FF0); end
      begin drive(1, ALU_MUL, 6, 7);  drive(1, ALU_OR, 32'h100, 32'h001); end
    join
    wait_idle();

    // T3: divide by zero
    drive(1, ALU_DIV, 9, 0);
    wait_idle();
    drive(0, ALU_REM, 17, 0);
    wait_idle();

    // T4: ALU never answers
    alu_sup = 1'b1;
    drive(0, ALU_ADD, 1, 2);
    wait_idle();
    alu_sup = 1'b0;

    // T5: response back-pressure with a pending requester
    rr_mode = 2;
    fork
      drive(0, ALU_MUL, 3, 4);
      begin @(posedge clk); #1; drive(1, ALU_ADD, 100, 23); end
      begin
        for (int k = 0; k < 50 && bus.resp_valid == 2'b00; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        rr_mode = 0;
      end
    join
    wait_idle();

    // T6: reset while waiting on a slow ALU; its late valid must be ignored
    alu_lat = 4;
    drive(0, ALU_ADD, 1, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 alu_lat = 1;

    // random traffic from both requesters with random back-pressure
    rr_mode = 1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rnd_drive(0);
        end
      end
      begin
        for (int m = 0; m < 40; m++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rnd_drive(1);
        end
      end
    join
    wait_idle();
    rr_mode = 0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
